fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter MEM_WAIT, default 1, giving the number of extra cycles mem_ren is held before read data is sampled (legal 0..15).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the fetch address loaded on reset.
REQ-003 The block SHALL use reset as its reset, asynchronous, active-low, and clock as its clock.
REQ-004 Ports:
  clock          in   1   rising-edge clock
  reset          in   1   asynchronous active-low reset
  mem_ren        out  1   instruction memory read enable
  mem_wen        out  1   instruction memory write enable, constant 0
  mem_addr       out  32  instruction memory address (= pc)
  mem_dout       in   32  instruction memory read data, combinational from mem_addr/mem_ren
  instr          out  32  fetched instruction word
  instr_pc       out  32  address of instr
  instr_pc4      out  32  instr_pc + 4 (mod 2^32)
  instr_valid    out  1   instr/instr_pc/instr_pc4 hold a valid instruction
  instr_ready    in   1   decode accepts instr this cycle
  redirect       in   1   branch/jump taken; refetch from redirect_pc
  redirect_pc    in   32  new fetch address
  fetch_err      out  1   sticky misaligned-redirect error

Function
REQ-005 The block SHALL implement states FETCH, VALID, ERROR, held in a register updated on rising clock.
REQ-006 The block SHALL drive mem_ren = 1 only in FETCH with reset high, mem_wen = 0 always, mem_addr = pc in all states.
REQ-007 In FETCH the block SHALL count wait cycles in a 4-bit counter cnt; at each rising edge: if cnt == MEM_WAIT, it SHALL capture mem_dout into instr, pc into instr_pc, pc+4 into instr_pc4, set instr_valid, set pc <= pc+4, clear cnt and enter VALID; otherwise cnt <= cnt+1.
REQ-008 Fetch latency SHALL be MEM_WAIT+1 cycles of mem_ren high; instr_valid SHALL rise at the edge ending the last such cycle.
REQ-009 In VALID the block SHALL hold instr, instr_pc, instr_pc4, instr_valid stable while instr_ready = 0.
REQ-010 In VALID with instr_ready = 1 at a rising edge, the block SHALL clear instr_valid and enter FETCH with cnt = 0 (sustained rate: one instruction per MEM_WAIT+2 cycles).
REQ-011 instr_ready SHALL be ignored outside VALID.
REQ-012 With redirect = 1 at a rising edge in FETCH or VALID and redirect_pc[1:0] == 0, the block SHALL set pc <= redirect_pc, cnt <= 0, instr_valid <= 0 and enter FETCH; any in-progress fetch is discarded without capture.
REQ-013 redirect SHALL take priority over capture (REQ-007) and accept (REQ-010) in the same cycle.
REQ-014 With redirect = 1 and redirect_pc[1:0] != 0, the block SHALL set fetch_err <= 1, instr_valid <= 0 and enter ERROR.
REQ-015 ERROR SHALL be absorbing until reset: mem_ren = 0, instr_valid = 0, redirect and instr_ready ignored, pc unchanged.
REQ-016 pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000); likewise instr_pc4.
REQ-017 instr SHALL hold mem_dout exactly as sampled; no decode or masking.

Reset
REQ-018 On reset low the block SHALL immediately (asynchronously) set pc = RESET_PC, state = FETCH, cnt = 0, instr = 0, instr_pc = 0, instr_pc4 = 0, instr_valid = 0, fetch_err = 0, and force mem_ren = 0.
REQ-019 Reset asserted mid-fetch or in VALID/ERROR SHALL abandon all state with no capture; after release, the first fetch SHALL start at RESET_PC on the next cycle.

Verification
REQ-020 MEM_WAIT=1, memory word 0 = 32'h0232_8020, instr_ready=1 -> mem_ren high 2 cycles at addr 0; instr=32'h0232_8020, instr_pc=0, instr_pc4=4, instr_valid high 1 cycle; next fetch at addr 4.
REQ-021 MEM_WAIT=0, instr_ready=0 for 5 cycles after valid -> outputs stable, mem_ren=0, pc=4; raise instr_ready -> valid drops next edge, fetch at addr 4.
REQ-022 In VALID with instr_ready=1, redirect=1, redirect_pc=32'h0000_0100 same cycle -> instruction not counted as accepted-and-advanced; next mem_addr=32'h100, instr_valid=0.
REQ-023 redirect mid-wait (MEM_WAIT=3, cnt=2) to 32'h40 -> no capture of old word; mem_ren held 4 cycles at 32'h40, then instr_pc=32'h40.
REQ-024 redirect_pc=32'h0000_0102 -> fetch_err=1, mem_ren=0, instr_valid=0 permanently; reset low then high -> fetch_err=0, fetch resumes at RESET_PC.
REQ-025 redirect_pc=32'hFFFF_FFFC -> instr_pc=32'hFFFF_FFFC, instr_pc4=0, next mem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a fixed memory wait,
// branch redirect, and a sticky error on misaligned redirect targets.
module fetch_unit #(
    parameter int unsigned MEM_WAIT = 1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);
    typedef enum logic [1:0] {FETCH, VALID, ERROR} state_t;
    localparam logic [3:0] WAIT = 4'(MEM_WAIT);

    state_t      state, state_n;
    logic [31:0] pc, pc_n, instr_n, instr_pc_n, instr_pc4_n;
    logic [3:0]  cnt, cnt_n;
    logic        instr_valid_n, fetch_err_n;

    assign mem_ren  = (state == FETCH) && reset;
    assign mem_wen  = 1'b0;
    assign mem_addr = pc;

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= FETCH;
        else        state <= state_n;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            pc          <= RESET_PC;
            cnt         <= 4'd0;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            instr_pc4   <= 32'd0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            pc          <= pc_n;
            cnt         <= cnt_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_pc4   <= instr_pc4_n;
            instr_valid <= instr_valid_n;
            fetch_err   <= fetch_err_n;
        end

    // Redirect outranks both capture and accept; ERROR ignores every input.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        cnt_n         = cnt;
        instr_n       = instr;
        instr_pc_n    = instr_pc;
        instr_pc4_n   = instr_pc4;
        instr_valid_n = instr_valid;
        fetch_err_n   = fetch_err;
        if (state != ERROR && redirect) begin
            instr_valid_n = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_err_n = 1'b1;
                state_n     = ERROR;
            end else begin
                pc_n    = redirect_pc;
                cnt_n   = 4'd0;
                state_n = FETCH;
            end
        end else if (state == FETCH) begin
            if (cnt == WAIT) begin
                instr_n       = mem_dout;
                instr_pc_n    = pc;
                instr_pc4_n   = pc + 32'd4;
                instr_valid_n = 1'b1;
                pc_n          = pc + 32'd4;
                cnt_n         = 4'd0;
                state_n       = VALID;
            end else begin
                cnt_n = cnt + 4'd1;
            end
        end else if (state == VALID && instr_ready) begin
            instr_valid_n = 1'b0;
            cnt_n         = 4'd0;
            state_n       = FETCH;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: three fetch units (waits 1, 0, 3) share stimulus; each is
// compared every cycle against a latency-counting model, plus directed checks.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] rpc = 32'd0;
    logic        ren [3], wen [3], valid [3], err [3];
    logic [31:0] addr [3], dout [3], instr [3], ipc [3], ipc4 [3];

    int          lat [3] = '{2, 1, 4};
    logic [31:0] rst_pc [3] = '{32'h0, 32'h0, 32'h200};

    logic        m_have [3], m_err [3];
    int          m_done [3];
    logic [31:0] m_pc [3], m_instr [3], m_ipc [3];
    logic        mon_en = 1'b0;
    int          checks = 0, errors = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a == 32'd0 ? 32'h0232_8020 : {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign dout[0] = memfn(addr[0]);
    assign dout[1] = memfn(addr[1]);
    assign dout[2] = memfn(addr[2]);

    fetch_unit #(.MEM_WAIT(1)) d0 (
        .clock(clock), .reset(reset), .mem_ren(ren[0]), .mem_wen(wen[0]), .mem_addr(addr[0]),
        .mem_dout(dout[0]), .instr(instr[0]), .instr_pc(ipc[0]), .instr_pc4(ipc4[0]),
        .instr_valid(valid[0]), .instr_ready(rdy), .redirect(rd), .redirect_pc(rpc), .fetch_err(err[0]));
    fetch_unit #(.MEM_WAIT(0)) d1 (
        .clock(clock), .reset(reset), .mem_ren(ren[1]), .mem_wen(wen[1]), .mem_addr(addr[1]),
        .mem_dout(dout[1]), .instr(instr[1]), .instr_pc(ipc[1]), .instr_pc4(ipc4[1]),
        .instr_valid(valid[1]), .instr_ready(rdy), .redirect(rd), .redirect_pc(rpc), .fetch_err(err[1]));
    fetch_unit #(.MEM_WAIT(3), .RESET_PC(32'h0000_0200)) d2 (
        .clock(clock), .reset(reset), .mem_ren(ren[2]), .mem_wen(wen[2]), .mem_addr(addr[2]),
        .mem_dout(dout[2]), .instr(instr[2]), .instr_pc(ipc[2]), .instr_pc4(ipc4[2]),
        .instr_valid(valid[2]), .instr_ready(rdy), .redirect(rd), .redirect_pc(rpc), .fetch_err(err[2]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d]: got %h expected %h", name, k, act, exp);
        end
    endtask

    // Model: count completed read cycles; a fetch lands after lat cycles.
    always @(posedge clock or negedge reset)
        for (int k = 0; k < 3; k++)
            if (!reset) begin
                m_pc[k] <= rst_pc[k];
                m_have[k] <= 1'b0;
                m_err[k] <= 1'b0;
                m_done[k] <= 0;
                m_instr[k] <= 32'd0;
                m_ipc[k] <= 32'd0;
            end else if (m_err[k]) begin
                m_err[k] <= 1'b1;
            end else if (rd) begin
                m_have[k] <= 1'b0;
                m_done[k] <= 0;
                if (rpc[1:0] != 2'b00) m_err[k] <= 1'b1;
                else m_pc[k] <= rpc;
            end else if (!m_have[k]) begin
                if (m_done[k] + 1 == lat[k]) begin
                    m_have[k] <= 1'b1;
                    m_instr[k] <= memfn(m_pc[k]);
                    m_ipc[k] <= m_pc[k];
                    m_pc[k] <= m_pc[k] + 32'd4;
                    m_done[k] <= 0;
                end else m_done[k] <= m_done[k] + 1;
            end else if (rdy) m_have[k] <= 1'b0;

    always @(negedge clock)
        if (mon_en)
            for (int k = 0; k < 3; k++) begin
                chk("m_ren", k, 32'(ren[k]), 32'(reset && !m_err[k] && !m_have[k]));
                chk("m_wen", k, 32'(wen[k]), 32'd0);
                chk("m_addr", k, addr[k], m_pc[k]);
                chk("m_valid", k, 32'(valid[k]), 32'(m_have[k]));
                chk("m_err", k, 32'(err[k]), 32'(m_err[k]));
                if (m_have[k]) begin
                    chk("m_instr", k, instr[k], m_instr[k]);
                    chk("m_ipc", k, ipc[k], m_ipc[k]);
                    chk("m_ipc4", k, ipc4[k], m_ipc[k] + 32'd4);
                end
            end

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        ren;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
        logic        err;
    } vec_t;
    vec_t tbl [15];

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic expect_d(input string name, input int k, input logic r, input logic [31:0] a,
                            input logic v, input logic [31:0] pc_i);
        chk({name, "_ren"}, k, 32'(ren[k]), 32'(r));
        chk({name, "_addr"}, k, addr[k], a);
        chk({name, "_valid"}, k, 32'(valid[k]), 32'(v));
        if (v) begin
            chk({name, "_ipc"}, k, ipc[k], pc_i);
            chk({name, "_ipc4"}, k, ipc4[k], pc_i + 32'd4);
            chk({name, "_instr"}, k, instr[k], memfn(pc_i));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h4,         1'b1, 32'h0,         1'b0};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, 32'h0,         1'b0};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8,         1'b1, 32'h4,         1'b0};
        tbl[5]  = '{1'b1, 32'h100,       1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         1'b0};
        tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h100,       1'b0, 32'h0,         1'b0};
        tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h104,       1'b1, 32'h100,       1'b0};
        tbl[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0};
        tbl[12] = '{1'b1, 32'h102,       1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
        tbl[13] = '{1'b1, 32'h40,        1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
        tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};

        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            expect_d("rst", k, 1'b0, rst_pc[k], 1'b0, 32'h0);
            chk("rst_instr", k, instr[k], 32'h0);
            chk("rst_ipc", k, ipc[k], 32'h0);
            chk("rst_ipc4", k, ipc4[k], 32'h0);
            chk("rst_err", k, 32'(err[k]), 32'd0);
        end
        mon_en = 1'b1;
        #1 reset = 1'b1;
        #1 chk("first_ren", 0, 32'(ren[0]), 32'd1);

        for (int i = 0; i < 15; i++) begin
            rd = tbl[i].rd;
            rpc = tbl[i].rpc;
            rdy = tbl[i].rdy;
            tick;
            expect_d($sformatf("tbl%0d", i), 0, tbl[i].ren, tbl[i].addr, tbl[i].valid, tbl[i].ipc);
            chk($sformatf("tbl%0d_err", i), 0, 32'(err[0]), 32'(tbl[i].err));
        end

        // Asynchronous reset out of ERROR.
        rd = 1'b0;
        rdy = 1'b0;
        #3 reset = 1'b0;
        #1 chk("err_clr", 0, 32'(err[0]), 32'd0);
        expect_d("async_rst", 0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_d("async_rst", 2, 1'b0, 32'h200, 1'b0, 32'h0);
        @(negedge clock);
        #1 reset = 1'b1;
        #1 expect_d("resume", 0, 1'b1, 32'h0, 1'b0, 32'h0);

        // Zero-wait unit holds its word while decode stalls.
        for (int i = 0; i < 6; i++) begin
            tick;
            expect_d($sformatf("hold%0d", i), 1, 1'b0, 32'h4, 1'b1, 32'h0);
        end
        rdy = 1'b1;
        tick;
        expect_d("accept", 1, 1'b1, 32'h4, 1'b0, 32'h0);

        // Redirect while the wait-3 unit is two cycles into a fetch.
        rdy = 1'b0;
        tick;
        tick;
        rd = 1'b1;
        rpc = 32'h40;
        tick;
        rd = 1'b0;
        expect_d("redir", 2, 1'b1, 32'h40, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick;
            expect_d($sformatf("redir_wait%0d", i), 2, 1'b1, 32'h40, 1'b0, 32'h0);
        end
        tick;
        expect_d("redir_cap", 2, 1'b0, 32'h44, 1'b1, 32'h40);

        // Reset in the middle of a fetch restarts from the reset address.
        rdy = 1'b1;
        tick;
        rdy = 1'b0;
        tick;
        #1 reset = 1'b0;
        tick;
        expect_d("midrst", 2, 1'b0, 32'h200, 1'b0, 32'h0);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            expect_d($sformatf("midrst_wait%0d", i), 2, 1'b1, 32'h200, 1'b0, 32'h0);
        end
        tick;
        expect_d("midrst_cap", 2, 1'b0, 32'h204, 1'b1, 32'h200);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            tick;
            r = $urandom;
            #1;
            reset = ($urandom_range(63) != 0);
            rd = ($urandom_range(7) == 0);
            rdy = 1'($urandom_range(1));
            rpc = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC
                : {r[31:2], ($urandom_range(15) == 0) ? 2'($urandom_range(3, 1)) : 2'b00};
        end
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
